// File: rtl/imm_ext_pipe_pkg.sv
// Shared immediate-extension types and widths for the decode/operand path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_imm_pkg;

  localparam int IMM16_W      = 16;  // raw MIPS immediate width
  localparam int WORD_W       = 32;  // datapath word width
  localparam int BR_SHIFT_DEF = 2;   // word-aligned branch offset shift

  typedef enum logic [1:0] {
    IMM_SIGN   = 2'd0,
    IMM_ZERO   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_t;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bundle for the immediate extender: decode-side beat in, operand-side beat out.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready, transfer on valid & ready at the rising edge.
// Ports: in_valid/in_ready/in_imm/in_mode/in_tag (upstream), out_valid/out_ready/out_data/out_tag/out_trunc (downstream).
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  import mips_imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  imm_mode_t        in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_trunc;

  // Environment side: drives input beats and downstream ready.
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_trunc
  );

  // Extender side.
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_trunc
  );

endinterface

// File: rtl/imm_ext_pipe_comb.sv
// Combinational immediate extender: sign / zero / upper / branch modes with truncation detect.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: imm_i (raw immediate), mode_i (extension mode) -> data_o (OUT_W result), trunc_o (significant bits lost).
module imm_ext_comb
  import mips_imm_pkg::*;
#(
  parameter int IN_W     = IMM16_W,
  parameter int OUT_W    = WORD_W,
  parameter int BR_SHIFT = BR_SHIFT_DEF
) (
  input  logic [IN_W-1:0]  imm_i,
  input  imm_mode_t        mode_i,
  output logic [OUT_W-1:0] data_o,
  output logic             trunc_o
);

  if (OUT_W < IN_W) begin : g_bad_out_w
    $error("imm_ext_comb: OUT_W must be >= IN_W");
  end
  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_ext_comb: IN_W must be >= 2");
  end
  if (BR_SHIFT < 0 || BR_SHIFT > 4) begin : g_bad_shift
    $error("imm_ext_comb: BR_SHIFT must be in 0..4");
  end

  // UPPER is formed in 2*IN_W bits; widen to OUT_W when the output is wider still.
  localparam int UP_W = (2 * IN_W > OUT_W) ? 2 * IN_W : OUT_W;
  // BRANCH is wide enough that no shifted-out bit is ever lost before the check.
  localparam int BR_W = IN_W + BR_SHIFT + OUT_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [UP_W-1:0]  up_wide;
  logic [BR_W-1:0]  br_wide;

  always_comb begin
    sext            = {OUT_W{imm_i[IN_W-1]}};
    sext[IN_W-1:0]  = imm_i;
    zext            = '0;
    zext[IN_W-1:0]  = imm_i;
    up_wide                   = '0;
    up_wide[2*IN_W-1:IN_W]    = imm_i;
    br_wide                   = {BR_W{imm_i[IN_W-1]}};
    br_wide[IN_W-1:0]         = imm_i;
    br_wide                   = br_wide << BR_SHIFT;

    data_o  = sext;
    trunc_o = 1'b0;
    case (mode_i)
      IMM_SIGN:  data_o = sext;
      IMM_ZERO:  data_o = zext;
      IMM_UPPER: begin
        data_o  = up_wide[OUT_W-1:0];
        trunc_o = |(up_wide >> OUT_W);
      end
      IMM_BRANCH: begin
        data_o  = br_wide[OUT_W-1:0];
        // Result still represents the value iff every dropped bit repeats the new sign bit.
        trunc_o = (br_wide[BR_W-1:OUT_W] != {(BR_W - OUT_W){br_wide[OUT_W-1]}});
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: one output register plus one skid register, strict FIFO order.
// Latency: 1 cycle (accept at edge N, out_valid after edge N); 1 beat/cycle with out_ready=1.
// Backpressure: in_ready = skid empty & not in reset, so it only depends on registered state.
// Ports: clk, reset (sync, active-high), bus (slave modport of imm_ext_pipe_if).
module imm_ext_pipe
  import mips_imm_pkg::*;
#(
  parameter int IN_W     = IMM16_W,
  parameter int OUT_W    = WORD_W,
  parameter int BR_SHIFT = BR_SHIFT_DEF,
  parameter int TAG_W    = 5
) (
  input  logic           clk,
  input  logic           reset,
  imm_ext_pipe_if.slave  bus
);

  logic [OUT_W-1:0] ext_data;
  logic             ext_trunc;

  imm_ext_comb #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_ext (
    .imm_i   (bus.in_imm),
    .mode_i  (bus.in_mode),
    .data_o  (ext_data),
    .trunc_o (ext_trunc)
  );

  logic             main_vld_q,   main_vld_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_trunc_q, main_trunc_d;
  logic             skid_vld_q,   skid_vld_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_trunc_q, skid_trunc_d;

  logic push;
  logic pop;

  assign bus.in_ready  = ~skid_vld_q & ~reset;
  assign bus.out_valid = main_vld_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.out_trunc = main_trunc_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = main_vld_q & bus.out_ready;

  always_comb begin
    main_vld_d   = main_vld_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    main_trunc_d = main_trunc_q;
    skid_vld_d   = skid_vld_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    skid_trunc_d = skid_trunc_q;

    // Pop first: main refills from skid if it holds the next-oldest beat.
    if (pop) begin
      main_vld_d   = skid_vld_q;
      main_data_d  = skid_data_q;
      main_tag_d   = skid_tag_q;
      main_trunc_d = skid_trunc_q;
      skid_vld_d   = 1'b0;
    end

    // push implies skid was empty, so a pop leaves main free for the new beat.
    if (push) begin
      if (!main_vld_q || pop) begin
        main_vld_d   = 1'b1;
        main_data_d  = ext_data;
        main_tag_d   = bus.in_tag;
        main_trunc_d = ext_trunc;
      end else begin
        skid_vld_d   = 1'b1;
        skid_data_d  = ext_data;
        skid_tag_d   = bus.in_tag;
        skid_trunc_d = ext_trunc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q   <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      main_trunc_q <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      skid_trunc_q <= 1'b0;
    end else begin
      main_vld_q   <= main_vld_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      main_trunc_q <= main_trunc_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      skid_trunc_q <= skid_trunc_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: main 16->32 instance with a queue-based scoreboard, plus 16->30 and 16->20 instances.
// Latency: n/a.
// Backpressure: driven directly and randomly on the main instance.
module tb_imm_ext_pipe;
  import mips_imm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
  imm_ext_pipe_if #(.IN_W(16), .OUT_W(30), .TAG_W(5)) b30 ();
  imm_ext_pipe_if #(.IN_W(16), .OUT_W(20), .TAG_W(5)) b20 ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  imm_ext_pipe #(.IN_W(16), .OUT_W(30), .BR_SHIFT(2), .TAG_W(5)) dut30 (
    .clk(clk), .reset(reset), .bus(b30));
  imm_ext_pipe #(.IN_W(16), .OUT_W(20), .BR_SHIFT(2), .TAG_W(5)) dut20 (
    .clk(clk), .reset(reset), .bus(b20));

  logic rdy_dir;
  logic rdy_rand;
  logic rnd_on;
  assign bus.out_ready = rnd_on ? rdy_rand : rdy_dir;
  assign b30.out_ready = 1'b1;
  assign b20.out_ready = 1'b1;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  tag;
    logic        tr;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value-level reference: form the exact mathematical result, then see whether it fits ow bits.
  function automatic void model(input logic [15:0] imm, input logic [1:0] mode, input int ow,
                                output logic [63:0] data, output logic trunc);
    longint s, full, sx;
    logic [63:0] mask, hb;
    s = longint'($signed(imm));
    case (mode)
      2'd0:    full = s;
      2'd1:    full = longint'({48'd0, imm});
      2'd2:    full = longint'({48'd0, imm}) * 65536;
      default: full = s * 4;
    endcase
    mask = (64'd1 << ow) - 64'd1;
    data = 64'(full) & mask;
    hb   = 64'd1 << (ow - 1);
    sx   = longint'(data ^ hb) - longint'(hb);
    case (mode)
      2'd2:    trunc = ((64'(full) >> ow) != 64'd0);
      2'd3:    trunc = (sx != full);
      default: trunc = 1'b0;
    endcase
  endfunction

  task automatic pin(input string name, input logic [15:0] imm, input logic [1:0] mode, input int ow,
                     input logic [63:0] exp_d, input logic exp_t);
    logic [63:0] d;
    logic t;
    model(imm, mode, ow, d, t);
    chk({name, "_data"}, d, exp_d);
    chk({name, "_trunc"}, {63'd0, t}, {63'd0, exp_t});
  endtask

  // Entered and left at posedge+1; holds in_valid until the beat is taken.
  task automatic push_beat(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    bit done = 0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = imm_mode_t'(mode);
    bus.in_tag   = tag;
    while (!done && n < 200) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("push_accepted", {63'd0, done}, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  // Single beat with out_ready=1: result must appear exactly one cycle after acceptance.
  task automatic send_chk(input string name, input logic [15:0] imm, input logic [1:0] mode,
                          input logic [4:0] tag, input logic [31:0] exp_d, input logic exp_t);
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = imm_mode_t'(mode);
    bus.in_tag   = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({name, "_data"},  {32'd0, bus.out_data}, {32'd0, exp_d});
    chk({name, "_tag"},   {59'd0, bus.out_tag}, {59'd0, tag});
    chk({name, "_trunc"}, {63'd0, bus.out_trunc}, {63'd0, exp_t});
    @(posedge clk);
    #1;
  endtask

  task automatic aux_round(input logic [15:0] i30, input logic [1:0] m30, input logic [29:0] e30, input logic t30,
                           input logic [15:0] i20, input logic [1:0] m20, input logic [19:0] e20, input logic t20);
    b30.in_valid = 1'b1; b30.in_imm = i30; b30.in_mode = imm_mode_t'(m30);
    b20.in_valid = 1'b1; b20.in_imm = i20; b20.in_mode = imm_mode_t'(m20);
    @(posedge clk);
    #1;
    b30.in_valid = 1'b0;
    b20.in_valid = 1'b0;
    @(negedge clk);
    chk("w30_valid", {63'd0, b30.out_valid}, 64'd1);
    chk("w30_data",  {34'd0, b30.out_data}, {34'd0, e30});
    chk("w30_trunc", {63'd0, b30.out_trunc}, {63'd0, t30});
    chk("w20_valid", {63'd0, b20.out_valid}, 64'd1);
    chk("w20_data",  {44'd0, b20.out_data}, {44'd0, e20});
    chk("w20_trunc", {63'd0, b20.out_trunc}, {63'd0, t20});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    rdy_dir      = 1'b1;
    rdy_rand     = 1'b1;
    rnd_on       = 1'b0;
    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = IMM_SIGN; bus.in_tag = '0;
    b30.in_valid = 1'b0; b30.in_imm = '0; b30.in_mode = IMM_SIGN; b30.in_tag = '0;
    b20.in_valid = 1'b0; b20.in_imm = '0; b20.in_mode = IMM_SIGN; b20.in_tag = '0;

    fork
      // Scoreboard: the pipe behaves as a FIFO of at most two already-extended beats.
      forever begin
        @(negedge clk);
        if (reset) begin
          exp_q.delete();
        end else begin
          chk("sb_out_valid", {63'd0, bus.out_valid}, {63'd0, exp_q.size() != 0});
          chk("sb_in_ready",  {63'd0, bus.in_ready},  {63'd0, exp_q.size() < 2});
          if (bus.out_valid && exp_q.size() != 0) begin
            chk("sb_data",  {32'd0, bus.out_data}, {32'd0, exp_q[0].d});
            chk("sb_tag",   {59'd0, bus.out_tag},  {59'd0, exp_q[0].tag});
            chk("sb_trunc", {63'd0, bus.out_trunc}, {63'd0, exp_q[0].tr});
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              n_out++;
            end
          end
          if (bus.in_valid && bus.in_ready) begin
            beat_t b;
            logic [63:0] d;
            logic t;
            model(bus.in_imm, bus.in_mode, 32, d, t);
            b.d = d[31:0];
            b.tag = bus.in_tag;
            b.tr = t;
            exp_q.push_back(b);
            n_in++;
          end
        end
      end
      forever begin
        @(posedge clk);
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
      end
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data",  {32'd0, bus.out_data}, 64'd0);
    chk("rst_out_tag",   {59'd0, bus.out_tag}, 64'd0);
    chk("rst_out_trunc", {63'd0, bus.out_trunc}, 64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pin the reference model to hand-computed values.
    pin("m_sign_pos", 16'h0017, 2'd0, 32, 64'h00000017, 1'b0);
    pin("m_sign_neg", 16'hFFE9, 2'd0, 32, 64'hFFFFFFE9, 1'b0);
    pin("m_zero",     16'hFFE9, 2'd1, 32, 64'h0000FFE9, 1'b0);
    pin("m_upper",    16'h1234, 2'd2, 32, 64'h12340000, 1'b0);
    pin("m_branch",   16'hFFFF, 2'd3, 32, 64'hFFFFFFFC, 1'b0);
    pin("m_br30",     16'h8000, 2'd3, 30, 64'h3FFE0000, 1'b0);
    pin("m_up20",     16'h1234, 2'd2, 20, 64'h00040000, 1'b1);
    pin("m_br_ovf",   16'h4000, 2'd3, 16, 64'h00000000, 1'b1);

    // Directed single beats on the 32-bit instance.
    send_chk("sign_pos", 16'h0017, 2'd0, 5'd1,  32'h00000017, 1'b0);
    send_chk("sign_neg", 16'hFFE9, 2'd0, 5'd2,  32'hFFFFFFE9, 1'b0);
    send_chk("zero",     16'hFFE9, 2'd1, 5'd3,  32'h0000FFE9, 1'b0);
    send_chk("upper",    16'h1234, 2'd2, 5'd4,  32'h12340000, 1'b0);
    send_chk("branch",   16'hFFFF, 2'd3, 5'd31, 32'hFFFFFFFC, 1'b0);

    // Narrower outputs.
    aux_round(16'h8000, 2'd3, 30'h3FFE0000, 1'b0, 16'h1234, 2'd2, 20'h40000, 1'b1);
    aux_round(16'h1234, 2'd2, 30'h12340000, 1'b0, 16'hFFE9, 2'd0, 20'hFFFE9, 1'b0);

    // Backpressure: third beat must be refused, held beat must not change.
    rdy_dir      = 1'b0;
    bus.in_valid = 1'b1; bus.in_imm = 16'h0100; bus.in_mode = IMM_SIGN; bus.in_tag = 5'd1;
    @(posedge clk); #1;
    bus.in_imm = 16'h0200; bus.in_tag = 5'd2;
    @(posedge clk); #1;
    bus.in_imm = 16'h0300; bus.in_tag = 5'd3;
    @(negedge clk);
    chk("bp_in_ready_full", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_head_tag", {59'd0, bus.out_tag}, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_tag",  {59'd0, bus.out_tag}, 64'd1);
    chk("bp_hold_data", {32'd0, bus.out_data}, 64'h100);
    @(posedge clk); #1;
    rdy_dir = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_tag2_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_tag2", {59'd0, bus.out_tag}, 64'd2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_tag3_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_tag3", {59'd0, bus.out_tag}, 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;

    // Full-rate random stream under random backpressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push_beat(16'($urandom), 2'($urandom_range(0, 3)), 5'($urandom));
    end
    rnd_on  = 1'b0;
    rdy_dir = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("stream_drain", 64'(exp_q.size()), 64'd0);
    chk("stream_no_loss", 64'(n_out), 64'(n_in));
    @(posedge clk); #1;

    // Reset with both entries occupied.
    rdy_dir = 1'b0;
    push_beat(16'h0AAA, 2'd1, 5'd7);
    push_beat(16'h0BBB, 2'd1, 5'd8);
    @(negedge clk);
    chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_in_ready",  {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    rdy_dir = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("post_rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    send_chk("post_rst", 16'h8001, 2'd3, 5'd9, 32'hFFFE0004, 1'b0);
    @(negedge clk);
    chk("post_rst_no_stale", {63'd0, bus.out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
